// File: rtl/apb_slave_regmem_pkg.sv
// rtl/apb_slave_regmem_pkg.sv - shared constants, FSM and decode types for apb_slave_regmem
package apb_slave_regmem_pkg;

  // CSR window, decoded on byte address bits [15:0]
  localparam logic [15:0] CSR_BASE      = 16'h8000;
  localparam logic [15:0] CSR_ID_OFFS   = 16'h0000;
  localparam logic [15:0] CSR_WAIT_OFFS = 16'h0004;
  localparam logic [15:0] CSR_WCNT_OFFS = 16'h0008;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic [2:0] {
    DEC_MEM,
    DEC_CSR_ID,
    DEC_CSR_WAIT,
    DEC_CSR_WCNT,
    DEC_NONE
  } dec_t;

  // Word-granular CSR match; byte lane bits are ignored
  function automatic logic csr_hit(input logic [15:0] addr, input logic [15:0] offs);
    return {addr[15:2], 2'b00} == (CSR_BASE | offs);
  endfunction

endpackage

// File: rtl/apb_slave_regmem_array.sv
// rtl/apb_slave_regmem_array.sv - single-port scratch RAM, synchronous write, registered read
module apb_slave_regmem_array #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Storage is deliberately left unreset so it maps onto block RAM
  logic [WIDTH-1:0] mem [DEPTH];

  // Write commits on the edge; read data is registered and held until the next read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_slave_regmem.sv
// rtl/apb_slave_regmem.sv - APB3 target with scratch RAM, ID/WAIT/WCNT CSRs and wait states (option: APB_SLAVE_REGMEM_SLVERR_EN)
module apb_slave_regmem
  import apb_slave_regmem_pkg::*;
#(
  parameter int                 APB_ADDR_WIDTH = 32,
  parameter int                 APB_DATA_WIDTH = 32,
  parameter int                 MEM_DEPTH      = 256,
  parameter logic [3:0]         WAIT_CYCLES    = 4'h0,
  parameter logic [31:0]        ID_VALUE       = 32'h5350_4D31
) (
  input  logic                      apb_pclk_i,
  input  logic                      apb_preset_i,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic                      apb_pwrite_i,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_t                    state, state_next;
  dec_t                      dec, dec_q;
  logic                      write_q;
  logic                      err, err_q;
  logic [IDX_W-1:0]          idx_q;
  logic [3:0]                cnt_q;
  logic [3:0]                csr_wait;
  logic [31:0]               csr_wcnt;
  logic [APB_DATA_WIDTH-1:0] csr_rd, csr_rdata_q;
  logic [APB_DATA_WIDTH-1:0] ram_rdata;
  logic [IDX_W-1:0]          ram_addr;
  logic                      ram_we, ram_re;
  logic                      setup, complete;
  logic [15:0]               addr_lo;
  logic                      unused_addr_bits;

  assign addr_lo          = apb_paddr_i[15:0];
  assign unused_addr_bits = ^{apb_paddr_i[APB_ADDR_WIDTH-1:16], apb_paddr_i[1:0]};

  // Setup phase is only recognised from IDLE; completion needs psel still held
  assign setup    = (state == IDLE) && apb_psel_i && !apb_penable_i;
  assign complete = (state == ACCESS) && apb_psel_i && (cnt_q == 4'd0);

  // Address decode of the live setup-phase address
  always_comb begin
    dec = DEC_NONE;
    if (addr_lo < 16'(MEM_DEPTH * 4)) begin
      dec = DEC_MEM;
    end else if (csr_hit(addr_lo, CSR_ID_OFFS)) begin
      dec = DEC_CSR_ID;
    end else if (csr_hit(addr_lo, CSR_WAIT_OFFS)) begin
      dec = DEC_CSR_WAIT;
    end else if (csr_hit(addr_lo, CSR_WCNT_OFFS)) begin
      dec = DEC_CSR_WCNT;
    end
  end

  // Error classification: unmapped, or a write to a read-only CSR
  always_comb begin
`ifdef APB_SLAVE_REGMEM_SLVERR_EN
    err = (dec == DEC_NONE) ||
          (apb_pwrite_i && ((dec == DEC_CSR_ID) || (dec == DEC_CSR_WCNT)));
`else
    err = 1'b0;
`endif
  end

  // CSR read mux sampled at setup; unmapped reads yield zero
  always_comb begin
    csr_rd = '0;
    case (dec)
      DEC_CSR_ID:   csr_rd = APB_DATA_WIDTH'(ID_VALUE);
      DEC_CSR_WAIT: csr_rd = APB_DATA_WIDTH'(csr_wait);
      DEC_CSR_WCNT: csr_rd = APB_DATA_WIDTH'(csr_wcnt);
      default:      csr_rd = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and APB response outputs
  always_comb begin
    state_next    = state;
    apb_pready_o  = 1'b0;
    apb_pslverr_o = 1'b0;
    apb_prdata_o  = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb_psel_i) begin
          state_next = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_next    = IDLE;
          apb_pready_o  = 1'b1;
          apb_pslverr_o = err_q;
          if (!write_q && !err_q) begin
            apb_prdata_o = (dec_q == DEC_MEM) ? ram_rdata : csr_rdata_q;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer context captured at setup; wait counter counts down in ACCESS
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      dec_q       <= DEC_NONE;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= 4'd0;
      csr_rdata_q <= '0;
    end else if (setup) begin
      dec_q       <= dec;
      write_q     <= apb_pwrite_i;
      err_q       <= err;
      idx_q       <= apb_paddr_i[IDX_W+1:2];
      cnt_q       <= csr_wait;
      csr_rdata_q <= csr_rd;
    end else if ((state == ACCESS) && apb_psel_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // CSR updates on completed, non-erroring writes
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      csr_wait <= WAIT_CYCLES;
      csr_wcnt <= 32'd0;
    end else if (complete && write_q && !err_q) begin
      csr_wcnt <= csr_wcnt + 32'd1;
      if (dec_q == DEC_CSR_WAIT) begin
        csr_wait <= apb_pwdata_i[3:0];
      end
    end
  end

  // RAM is read during setup and written at completion, so one port suffices
  assign ram_re   = setup && (dec == DEC_MEM);
  assign ram_we   = complete && write_q && !err_q && (dec_q == DEC_MEM);
  assign ram_addr = (state == IDLE) ? apb_paddr_i[IDX_W+1:2] : idx_q;

  apb_slave_regmem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (APB_DATA_WIDTH)
  ) u_array (
    .clk   (apb_pclk_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (apb_pwdata_i),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regmem.sv
// tb/tb_apb_slave_regmem.sv - directed self-checking bench for apb_slave_regmem
module tb_apb_slave_regmem;

`ifdef APB_SLAVE_REGMEM_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        se;
  int          cyc;
  logic [31:0] exp_wcnt;

  apb_slave_regmem dut (
    .apb_pclk_i    (clk),
    .apb_preset_i  (rst),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_paddr_i   (paddr),
    .apb_pwrite_i  (pwrite),
    .apb_pwdata_i  (pwdata),
    .apb_prdata_o  (prdata),
    .apb_pready_o  (pready),
    .apb_pslverr_o (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns the access cycle in which pready rose
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic slverr, output int cycles);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles  = 1;
    @(negedge clk);
    while (!pready && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    rdata  = prdata;
    slverr = pslverr;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pready", {31'd0, pready}, 32'd0);
    check("reset_prdata", prdata, 32'd0);
    check("reset_pslverr", {31'd0, pslverr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_wcnt = 32'd0;

    xfer(32'h8000, 1'b0, 32'd0, rd, se, cyc);
    check("id_data", rd, 32'h5350_4D31);
    check("id_cycles", cyc, 32'd1);
    check("id_slverr", {31'd0, se}, 32'd0);

    // Back-to-back write then read of the same word
    xfer(32'h0010, 1'b1, 32'hDEAD_BEEF, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wr10_cycles", cyc, 32'd1);
    check("wr10_prdata", rd, 32'd0);
    xfer(32'h0010, 1'b0, 32'd0, rd, se, cyc);
    check("rd10_data", rd, 32'hDEAD_BEEF);
    xfer(32'h8008, 1'b0, 32'd0, rd, se, cyc);
    check("wcnt_1", rd, 32'd1);

    // CSR_WAIT=3 takes effect from the following transfer
    xfer(32'h8004, 1'b1, 32'h0000_0003, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wait3_own_cycles", cyc, 32'd1);
    xfer(32'h0004, 1'b1, 32'h1234_5678, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wr04_cycles", cyc, 32'd4);
    xfer(32'h0004, 1'b0, 32'd0, rd, se, cyc);
    check("rd04_cycles", cyc, 32'd4);
    check("rd04_data", rd, 32'h1234_5678);
    xfer(32'h8006, 1'b0, 32'd0, rd, se, cyc);
    check("rd_wait_bytelane", rd, 32'd3);

    // Abort: CSR_WAIT=5, drop psel after one wait cycle
    xfer(32'h8004, 1'b1, 32'h0000_0005, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wait5_cycles", cyc, 32'd4);
    xfer(32'h0020, 1'b1, 32'h1111_2222, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wr20_cycles", cyc, 32'd6);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0020; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_drop_pready", {30'd0, pready, pslverr}, 32'd0);
    @(posedge clk); #1;
    xfer(32'h0020, 1'b0, 32'd0, rd, se, cyc);
    check("rd20_after_abort", rd, 32'h1111_2222);
    check("rd20_cycles", cyc, 32'd6);
    xfer(32'h8008, 1'b0, 32'd0, rd, se, cyc);
    check("wcnt_after_abort", rd, 32'd5);

    // Back to zero wait; memory top boundary and error responses
    xfer(32'h8004, 1'b1, 32'h0000_0000, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    xfer(32'h0000_03FC, 1'b1, 32'h3C3C_3C3C, rd, se, cyc);
    exp_wcnt = exp_wcnt + 1;
    check("wr3fc_cycles", cyc, 32'd1);
    xfer(32'hFFFF_03FC, 1'b0, 32'd0, rd, se, cyc);
    check("rd3fc_alias", rd, 32'h3C3C_3C3C);
    xfer(32'h0000_0400, 1'b0, 32'd0, rd, se, cyc);
    check("rd400_data", rd, 32'd0);
    check("rd400_slverr", {31'd0, se}, {31'd0, EXP_ERR});
    xfer(32'h0000_4000, 1'b0, 32'd0, rd, se, cyc);
    check("rd4000_data", rd, 32'd0);
    check("rd4000_slverr", {31'd0, se}, {31'd0, EXP_ERR});
    xfer(32'h8008, 1'b1, 32'h0000_0099, rd, se, cyc);
    if (!EXP_ERR) exp_wcnt = exp_wcnt + 1;
    check("wr_wcnt_slverr", {31'd0, se}, {31'd0, EXP_ERR});
    xfer(32'h8008, 1'b0, 32'd0, rd, se, cyc);
    check("wcnt_after_ro_write", rd, exp_wcnt);
    check("wcnt_hand_value", rd, EXP_ERR ? 32'd7 : 32'd8);

    // Reset in the middle of a waited write
    xfer(32'h0030, 1'b1, 32'h0BAD_F00D, rd, se, cyc);
    xfer(32'h8004, 1'b1, 32'h0000_0005, rd, se, cyc);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0030; pwrite = 1'b1; pwdata = 32'hCAFE_0000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_pready", {31'd0, pready}, 32'd0);
    check("rst_mid_prdata", prdata, 32'd0);
    check("rst_mid_pslverr", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(32'h8004, 1'b0, 32'd0, rd, se, cyc);
    check("wait_after_reset", rd, 32'd0);
    check("wait_after_reset_cycles", cyc, 32'd1);
    xfer(32'h0030, 1'b0, 32'd0, rd, se, cyc);
    check("rd30_not_committed", rd, 32'h0BAD_F00D);
    xfer(32'h8008, 1'b0, 32'd0, rd, se, cyc);
    check("wcnt_after_reset", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
